cm0ik_ahb_sram_mem: RTL

- Single-port synchronous 32-bit embedded SRAM with byte-lane write enables. It sits directly downstream of the AHB-Lite-to-SRAM bridge and consumes its RAMAD/RAMWD/RAMCS/RAMWE, returning RAMRD.
- Contains a hardware fill engine that writes every word with a fixed pattern after reset, or on request.
- INITDONE qualifies the memory for use. System integration holds the core in reset until INITDONE=1.

---
 rtl/cm0ik_sram_pkg.sv | 13 +
 rtl/cm0ik_sram_fill_ctrl.sv | 79 +++++++
 rtl/cm0ik_ahb_sram_mem.sv | 81 ++++++++
 3 files changed

// File: rtl/cm0ik_sram_pkg.sv
// Shared definitions for the embedded SRAM: fill-controller state encoding
// and the byte-lane geometry of a 32-bit word.
package cm0ik_sram_pkg;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_READY = 1'b1
  } fill_state_e;

  localparam int BYTE  = 8;
  localparam int LANES = 4;

endpackage

// File: rtl/cm0ik_sram_fill_ctrl.sv
// Fill engine: sweeps every word with the fill pattern after reset or on
// request, gates normal accesses until done, and flags accesses made meanwhile.
module cm0ik_sram_fill_ctrl
  import cm0ik_sram_pkg::*;
#(
  parameter int WAW     = 4,
  parameter bit INIT_EN = 1'b1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_initreq,
  input  logic           i_cs,
  output logic [WAW-1:0] o_fill_addr,
  output logic           o_fill_we,
  output logic           o_acc_ok,
  output logic           o_initdone,
  output logic           o_accerr
);

  localparam fill_state_e    ST_RESET = INIT_EN ? ST_FILL : ST_READY;
  localparam logic [WAW-1:0] LAST     = '1;

  fill_state_e    r_state;
  fill_state_e    w_state_next;
  logic [WAW-1:0] r_cnt;
  logic [WAW-1:0] w_cnt_next;
  logic           r_initdone;
  logic           w_initdone_next;
  logic           r_accerr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_RESET;
      r_cnt      <= '0;
      r_initdone <= !INIT_EN;
      r_accerr   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_initdone <= w_initdone_next;
      // Any select seen while filling is dropped and reported one cycle later.
      r_accerr   <= (r_state == ST_FILL) && i_cs;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_initdone_next = r_initdone;
    case (r_state)
      ST_FILL: begin
        if (r_cnt == LAST) begin
          w_state_next    = ST_READY;
          w_cnt_next      = '0;
          w_initdone_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_READY: begin
        if (i_initreq) begin
          w_state_next    = ST_FILL;
          w_cnt_next      = '0;
          w_initdone_next = 1'b0;
        end
      end
      default: begin
        w_state_next = ST_RESET;
      end
    endcase
  end

  assign o_fill_addr = r_cnt;
  assign o_fill_we   = (r_state == ST_FILL);
  assign o_acc_ok    = (r_state == ST_READY);
  assign o_initdone  = r_initdone;
  assign o_accerr    = r_accerr;

endmodule

// File: rtl/cm0ik_ahb_sram_mem.sv
// Single-port 32-bit SRAM with byte-lane writes and a registered read port,
// fed by the AHB-Lite SRAM bridge; a fill engine owns the array until INITDONE.
module cm0ik_ahb_sram_mem
  import cm0ik_sram_pkg::*;
#(
  parameter int          AWIDTH   = 12,
  parameter bit          INIT_EN  = 1'b1,
  parameter logic [31:0] INIT_VAL = 32'h0000_0000
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic [AWIDTH-3:0] RAMAD,
  input  logic [31:0]       RAMWD,
  input  logic              RAMCS,
  input  logic [3:0]        RAMWE,
  output logic [31:0]       RAMRD,
  input  logic              INITREQ,
  output logic              INITDONE,
  output logic              ACCERR
);

  localparam int WAW   = AWIDTH - 2;
  localparam int DEPTH = 1 << WAW;

  logic [WAW-1:0]   w_fill_addr;
  logic             w_fill_we;
  logic             w_acc_ok;
  logic             w_access;
  logic             w_rd_en;
  logic [WAW-1:0]   w_addr;
  logic [31:0]      w_wdata;
  logic [LANES-1:0] w_lane_we;

  logic [31:0]      r_mem [DEPTH];
  logic [31:0]      r_rd;

  cm0ik_sram_fill_ctrl #(
    .WAW     (WAW),
    .INIT_EN (INIT_EN)
  ) u_fill_ctrl (
    .i_clk       (HCLK),
    .i_rst       (HRESET),
    .i_initreq   (INITREQ),
    .i_cs        (RAMCS),
    .o_fill_addr (w_fill_addr),
    .o_fill_we   (w_fill_we),
    .o_acc_ok    (w_acc_ok),
    .o_initdone  (INITDONE),
    .o_accerr    (ACCERR)
  );

  // The bridge drives RAMWE even when deselected, so strobes only count under RAMCS.
  assign w_access = w_acc_ok && RAMCS;
  assign w_rd_en  = w_access && (RAMWE == 4'b0000);
  assign w_addr   = w_fill_we ? w_fill_addr : RAMAD;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign w_lane_we[gi] = w_fill_we || (w_access && RAMWE[gi]);
    assign w_wdata[gi*BYTE +: BYTE] = w_fill_we ? INIT_VAL[gi*BYTE +: BYTE]
                                                : RAMWD[gi*BYTE +: BYTE];
  end

  always_ff @(posedge HCLK) begin
    for (int i = 0; i < LANES; i++) begin
      if (w_lane_we[i]) begin
        r_mem[w_addr][i*BYTE +: BYTE] <= w_wdata[i*BYTE +: BYTE];
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_rd <= '0;
    end else if (w_rd_en) begin
      r_rd <= r_mem[RAMAD];
    end
  end

  assign RAMRD = r_rd;

endmodule
